// File: rtl/bus_ctrl.sv
// -----------------------------------------------------------------------------
// bus_ctrl
// Sits between the CPU core and external synchronous RAM. Accepts one CPU
// access at a time and either services it from the on-block I/O page
// (output port, synchronised input port, 16-bit cycle timer) or runs a RAM
// cycle with WAIT_STATES extra cycles. Completion is signalled by a single
// cycle RDY pulse.
//
// Ports:
//   CLK       - system clock, rising edge
//   R         - asynchronous active-low reset
//   REQ       - CPU access request, held until RDY
//   ADDR      - CPU address
//   DIN       - CPU write data
//   WE        - 1 = write, 0 = read, sampled with REQ
//   RDY       - one-cycle completion pulse
//   DOUT      - read data, valid with RDY and held afterwards
//   MEM_ADDR  - RAM address
//   MEM_DIN   - RAM write data
//   MEM_WE    - RAM write enable
//   MEM_DOUT  - RAM read data, valid one cycle after MEM_ADDR is stable
//   PORT_IN   - asynchronous external input pins
//   PORT_OUT  - output port register
// -----------------------------------------------------------------------------
module bus_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        CLK,
    input  logic        R,
    input  logic        REQ,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DIN,
    input  logic        WE,
    output logic        RDY,
    output logic [7:0]  DOUT,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_DIN,
    output logic        MEM_WE,
    input  logic [7:0]  MEM_DOUT,
    input  logic [7:0]  PORT_IN,
    output logic [7:0]  PORT_OUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAM  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t      state_q;
    logic        we_q;
    logic [3:0]  cnt_q;
    logic        rdy_q;
    logic [7:0]  dout_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_din_q;
    logic        mem_we_q;
    logic [7:0]  port_out_q;
    logic [15:0] timer_q;
    logic        tmr_en_q;
    logic [7:0]  hi_q;
    logic [7:0]  sync1_q;
    logic [7:0]  sync2_q;

    logic        is_io_d;
    logic        io_acc_d;
    logic        tmr_clr_d;
    logic [7:0]  io_rdata_d;
    logic [15:0] timer_d;

    always_comb begin
        is_io_d    = (ADDR[15:4] == IO_BASE[15:4]);
        io_acc_d   = (state_q == S_IDLE) && REQ && is_io_d;
        tmr_clr_d  = io_acc_d && WE && (ADDR[3:0] == 4'd4) && DIN[1];

        io_rdata_d = 8'h00;
        case (ADDR[3:0])
            4'd0:    io_rdata_d = port_out_q;
            4'd1:    io_rdata_d = sync2_q;
            4'd2:    io_rdata_d = timer_q[7:0];
            4'd3:    io_rdata_d = hi_q;
            4'd4:    io_rdata_d = {7'd0, tmr_en_q};
            default: io_rdata_d = 8'h00;
        endcase

        // Clear has priority over the running increment.
        if (tmr_clr_d) begin
            timer_d = 16'h0000;
        end else if (tmr_en_q) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            cnt_q      <= 4'd0;
            rdy_q      <= 1'b0;
            dout_q     <= 8'h00;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 8'h00;
            mem_we_q   <= 1'b0;
            port_out_q <= 8'h00;
            timer_q    <= 16'h0000;
            tmr_en_q   <= 1'b0;
            hi_q       <= 8'h00;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
        end else begin
            sync1_q <= PORT_IN;
            sync2_q <= sync1_q;
            timer_q <= timer_d;

            case (state_q)
                S_IDLE: begin
                    rdy_q <= 1'b0;
                    if (REQ) begin
                        we_q <= WE;
                        if (is_io_d) begin
                            // I/O is serviced at the acceptance edge itself.
                            if (WE) begin
                                if (ADDR[3:0] == 4'd0) port_out_q <= DIN;
                                if (ADDR[3:0] == 4'd4) tmr_en_q   <= DIN[0];
                            end else begin
                                dout_q <= io_rdata_d;
                                if (ADDR[3:0] == 4'd2) hi_q <= timer_q[15:8];
                            end
                            rdy_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            mem_addr_q <= ADDR;
                            mem_din_q  <= DIN;
                            cnt_q      <= WS_INIT;
                            // With no wait states the first RAM cycle is also the last.
                            mem_we_q   <= WE && (WS_INIT == 4'd0);
                            state_q    <= S_RAM;
                        end
                    end
                end
                S_RAM: begin
                    if (cnt_q == 4'd0) begin
                        mem_we_q <= 1'b0;
                        if (!we_q) dout_q <= MEM_DOUT;
                        rdy_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q    <= cnt_q - 4'd1;
                        // Registered so it is high exactly during the cnt==0 cycle.
                        mem_we_q <= we_q && (cnt_q == 4'd1);
                    end
                end
                S_DONE: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign RDY      = rdy_q;
    assign DOUT     = dout_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DIN  = mem_din_q;
    assign MEM_WE   = mem_we_q;
    assign PORT_OUT = port_out_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_ctrl
// Directed bench for bus_ctrl. Instance dut uses WAIT_STATES=2, instance dut3
// uses WAIT_STATES=3 and is only requested in the reset-abort scenario.
// A small synchronous RAM model backs both instances.
// -----------------------------------------------------------------------------
module tb_bus_ctrl;

    logic        CLK = 1'b0;
    logic        R   = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ3 = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [7:0]  DIN = 8'h00;
    logic        WE = 1'b0;
    logic [7:0]  PORT_IN = 8'h00;
    logic [7:0]  MEM_DOUT = 8'h00;
    logic [7:0]  MEM_DOUT3 = 8'h00;

    logic        RDY, RDY3;
    logic [7:0]  DOUT, DOUT3;
    logic [15:0] MEM_ADDR, MEM_ADDR3;
    logic [7:0]  MEM_DIN, MEM_DIN3;
    logic        MEM_WE, MEM_WE3;
    logic [7:0]  PORT_OUT, PORT_OUT3;

    logic [7:0]  mem [0:4095];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    bus_ctrl #(.WAIT_STATES(2), .IO_BASE(16'hFF00)) dut (
        .CLK(CLK), .R(R), .REQ(REQ), .ADDR(ADDR), .DIN(DIN), .WE(WE),
        .RDY(RDY), .DOUT(DOUT), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_WE(MEM_WE), .MEM_DOUT(MEM_DOUT), .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT)
    );

    bus_ctrl #(.WAIT_STATES(3), .IO_BASE(16'hFF00)) dut3 (
        .CLK(CLK), .R(R), .REQ(REQ3), .ADDR(ADDR), .DIN(DIN), .WE(WE),
        .RDY(RDY3), .DOUT(DOUT3), .MEM_ADDR(MEM_ADDR3), .MEM_DIN(MEM_DIN3),
        .MEM_WE(MEM_WE3), .MEM_DOUT(MEM_DOUT3), .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT3)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MEM_WE) mem[MEM_ADDR[11:0]] <= MEM_DIN;
        MEM_DOUT  <= mem[MEM_ADDR[11:0]];
        MEM_DOUT3 <= mem[MEM_ADDR3[11:0]];
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One CPU access on dut (sel=0) or dut3 (sel=1). Records per-cycle MEM_WE
    // (oldest in the higher bits, including the RDY cycle), the number of
    // cycles MEM_ADDR showed the access address, and the acceptance edge.
    task automatic acc(input bit sel, input logic [15:0] a, input logic [7:0] d,
                       input logic w, output int lat, output logic [7:0] weseq,
                       output int acyc, output int aedge);
        logic        r;
        logic        mw;
        logic [15:0] ma;
        lat = 0; weseq = 8'h00; acyc = 0; aedge = 0; r = 1'b0;
        ADDR = a; DIN = d; WE = w;
        if (sel) REQ3 = 1'b1; else REQ = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            lat++;
            if (lat == 1) aedge = cyc;
            r  = sel ? RDY3 : RDY;
            mw = sel ? MEM_WE3 : MEM_WE;
            ma = sel ? MEM_ADDR3 : MEM_ADDR;
            weseq = {weseq[6:0], mw};
            if (r) break;
            if (ma == a) acyc++;
        end
        REQ = 1'b0; REQ3 = 1'b0;
        chk("rdy_seen", {31'd0, r}, 32'd1);
        tick;
    endtask

    task automatic wait_edge(input int m);
        while (cyc < m - 1) tick;
    endtask

    int          lat, acyc, aedge, n_en, c_clr;
    logic [7:0]  weseq;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Reset state
        #12;
        chk("rst_rdy",      {31'd0, RDY},      32'd0);
        chk("rst_dout",     {24'd0, DOUT},     32'h00);
        chk("rst_mem_addr", {16'd0, MEM_ADDR}, 32'h0000);
        chk("rst_mem_din",  {24'd0, MEM_DIN},  32'h00);
        chk("rst_mem_we",   {31'd0, MEM_WE},   32'd0);
        chk("rst_port_out", {24'd0, PORT_OUT}, 32'h00);
        R = 1'b1;
        tick; tick;

        // RAM write 0200=A5
        acc(0, 16'h0200, 8'hA5, 1'b1, lat, weseq, acyc, aedge);
        chk("ramwr_lat",   lat,   32'd4);
        chk("ramwr_we",    weseq, 32'h02);
        chk("ramwr_addr",  acyc,  32'd3);
        chk("ramwr_dout",  DOUT,  32'h00);
        chk("ramwr_mem",   mem[12'h200], 32'hA5);

        // RAM read 0200
        acc(0, 16'h0200, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("ramrd_lat",   lat,   32'd4);
        chk("ramrd_we",    weseq, 32'h00);
        chk("ramrd_dout",  DOUT,  32'hA5);

        // RAM write 0300 leaves DOUT alone
        acc(0, 16'h0300, 8'h5C, 1'b1, lat, weseq, acyc, aedge);
        chk("ramwr2_dout", DOUT,  32'hA5);
        chk("ramwr2_mem",  mem[12'h300], 32'h5C);

        // Output port write / read
        acc(0, 16'hFF00, 8'h3C, 1'b1, lat, weseq, acyc, aedge);
        chk("pout_wr_lat", lat,      32'd1);
        chk("pout_value",  PORT_OUT, 32'h3C);
        chk("pout_no_we",  weseq,    32'h00);
        chk("pout_dout",   DOUT,     32'hA5);
        acc(0, 16'hFF00, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("pout_rd_lat", lat,  32'd1);
        chk("pout_rd",     DOUT, 32'h3C);

        // Unmapped offset: write ignored, reads zero
        acc(0, 16'hFF05, 8'h99, 1'b1, lat, weseq, acyc, aedge);
        acc(0, 16'hFF05, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("unmapped_rd", DOUT, 32'h00);

        // Synchronised input port
        PORT_IN = 8'h81;
        tick; tick;
        acc(0, 16'hFF01, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("pin_rd", DOUT, 32'h81);

        // Timer enable; value seen by a read accepted at edge M is M-1-n_en
        acc(0, 16'hFF04, 8'h01, 1'b1, lat, weseq, acyc, aedge);
        n_en = aedge;
        acc(0, 16'hFF04, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("ctrl_rd_en", DOUT, 32'h01);

        wait_edge(n_en + 1 + 32'h12FE);
        acc(0, 16'hFF02, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("tlo_12fe", DOUT, 32'hFE);
        wait_edge(n_en + 1 + 32'h1305);
        acc(0, 16'hFF03, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("thi_latch", DOUT, 32'h12);

        wait_edge(n_en + 1 + 32'hFFFE);
        acc(0, 16'hFF02, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("tlo_fffe", DOUT, 32'hFE);
        acc(0, 16'hFF03, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("thi_ff", DOUT, 32'hFF);
        wait_edge(n_en + 1 + 32'h10002);
        acc(0, 16'hFF02, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("tlo_wrap", DOUT, 32'h02);
        acc(0, 16'hFF03, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("thi_wrap", DOUT, 32'h00);

        // Clear while enabled
        acc(0, 16'hFF04, 8'h03, 1'b1, lat, weseq, acyc, aedge);
        c_clr = aedge;
        wait_edge(c_clr + 1 + 5);
        acc(0, 16'hFF02, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("tclr_count", DOUT, 32'h05);
        acc(0, 16'hFF04, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("ctrl_rd_clr", DOUT, 32'h01);
        acc(0, 16'hFF09, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("rd_ff09", DOUT, 32'h00);

        // Reset abort on the WAIT_STATES=3 instance
        acc(1, 16'hFF00, 8'h5A, 1'b1, lat, weseq, acyc, aedge);
        chk("d3_pout", PORT_OUT3, 32'h5A);
        ADDR = 16'h0400; DIN = 8'h77; WE = 1'b1; REQ3 = 1'b1;
        tick; tick; tick; tick;
        chk("d3_we_final", {31'd0, MEM_WE3}, 32'd1);
        chk("d3_addr",     MEM_ADDR3,        32'h0400);
        #2 R = 1'b0;
        REQ3 = 1'b0;
        #1;
        chk("abort_we",    {31'd0, MEM_WE3}, 32'd0);
        chk("abort_rdy",   {31'd0, RDY3},    32'd0);
        chk("abort_pout3", PORT_OUT3,        32'h00);
        chk("abort_pout",  PORT_OUT,         32'h00);
        tick;
        R = 1'b1;
        tick;
        chk("abort_no_wr", mem[12'h400], 32'h00);
        acc(1, 16'h0200, 8'h00, 1'b0, lat, weseq, acyc, aedge);
        chk("d3_rd_lat",  lat,   32'd5);
        chk("d3_rd_addr", acyc,  32'd4);
        chk("d3_rd_we",   weseq, 32'h00);
        chk("d3_rd_dout", DOUT3, 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
